// File: rtl/keccak_msg_feeder.sv
// keccak_msg_feeder
//   Front end for the Kyber hash core input FIFO. Accepts a valid/ready stream
//   of 32-bit little-endian message words and writes them to the FIFO,
//   applying FIPS-202 domain separation and pad10*1 padding and splitting the
//   stream into rate-sized blocks.
//
//   Build option: define KECCAK_FEED_PAD_EN for full padding/block splitting.
//   Without it, words pass straight through, ififo_last follows in_last,
//   empty_msg is ignored and blk_cnt counts messages since reset.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   start            one-cycle start pulse, honoured only when idle
//   mode             00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512
//   empty_msg        message has zero bytes (sampled on start)
//   in_valid/ready   message word handshake
//   in_data/last     message word (byte 0 in [7:0]) and final-word flag
//   in_bytes         valid bytes (1..4) in the final word
//   ififo_full       hash-core FIFO full
//   ififo_wen/din    FIFO write strobe and data
//   ififo_absorb     high with every write
//   ififo_mode       latched mode
//   ififo_last       final word of a rate block
//   busy, done       not idle; one-cycle pulse after the last write
//   blk_cnt          blocks emitted (messages in pass-through build), sat. 255
module keccak_msg_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        empty_msg,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  input  logic        ififo_full,
  output logic        ififo_wen,
  output logic [31:0] ififo_din,
  output logic        ififo_absorb,
  output logic [1:0]  ififo_mode,
  output logic        ififo_last,
  output logic        busy,
  output logic        done,
  output logic [7:0]  blk_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MSG = 2'd1, S_PAD = 2'd2} state_t;

  state_t      state;
  logic [1:0]  mode_q;
  logic        rdy;
  logic        wen;
  logic [31:0] din;
  logic        lst;

  assign in_ready     = rdy;
  assign ififo_wen    = wen;
  assign ififo_din    = din;
  assign ififo_absorb = wen;
  assign ififo_last   = lst;
  assign ififo_mode   = mode_q;
  assign busy         = (state != S_IDLE);

`ifdef KECCAK_FEED_PAD_EN

  logic [5:0]  wctr;
  logic        pend;      // suffix byte still owed to the stream
  logic [5:0]  rate_m1;
  logic [7:0]  suffix;
  logic [31:0] part_word;
  logic        at_end;
  logic        blk_end;   // this write closes a rate block
  logic        fin;       // this write is the final one of the message

  assign suffix = mode_q[1] ? 8'h06 : 8'h1F;
  assign at_end = (wctr == rate_m1);

  always_comb begin
    case (mode_q)
      2'b00:   rate_m1 = 6'd41;
      2'b11:   rate_m1 = 6'd17;
      default: rate_m1 = 6'd33;
    endcase
  end

  // Short final word: keep valid lanes, suffix in the first free lane,
  // zero above it.
  always_comb begin
    part_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < in_bytes)
        part_word[8*i +: 8] = in_data[8*i +: 8];
      else if (3'(i) == in_bytes)
        part_word[8*i +: 8] = suffix;
    end
  end

  always_comb begin
    rdy     = 1'b0;
    wen     = 1'b0;
    din     = '0;
    lst     = 1'b0;
    blk_end = 1'b0;
    fin     = 1'b0;
    case (state)
      S_MSG: begin
        rdy = ~ififo_full;
        wen = in_valid & ~ififo_full;
        din = (in_last & ~in_bytes[2]) ? part_word : in_data;
        if (at_end) begin
          lst     = 1'b1;
          blk_end = 1'b1;
          // Only a short final word completes the padding here; a full
          // final word leaves the suffix for the next block.
          if (in_last & ~in_bytes[2]) begin
            din[31] = 1'b1;
            fin     = 1'b1;
          end
        end
      end
      S_PAD: begin
        wen = ~ififo_full;
        din = pend ? {24'h0, suffix} : 32'h0;
        if (at_end) begin
          din[31] = 1'b1;
          lst     = 1'b1;
          blk_end = 1'b1;
          fin     = 1'b1;
        end
      end
      default: ;
    endcase
    if (!wen) begin
      din = '0;
      lst = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mode_q  <= 2'b00;
      wctr    <= '0;
      pend    <= 1'b0;
      blk_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          mode_q  <= mode;
          wctr    <= '0;
          blk_cnt <= '0;
          pend    <= empty_msg;
          state   <= empty_msg ? S_PAD : S_MSG;
        end
      end else if (wen) begin
        wctr <= blk_end ? 6'd0 : wctr + 6'd1;
        if (blk_end && blk_cnt != 8'hFF)
          blk_cnt <= blk_cnt + 8'd1;
        if (state == S_MSG) begin
          if (in_last) begin
            if (fin) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_PAD;
              pend  <= in_bytes[2];
            end
          end
        end else begin
          pend <= 1'b0;
          if (fin) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

`else

  logic unused_in;
  assign unused_in = ^{empty_msg, in_bytes};

  always_comb begin
    rdy = 1'b0;
    wen = 1'b0;
    din = '0;
    lst = 1'b0;
    if (state == S_MSG) begin
      rdy = ~ififo_full;
      wen = in_valid & ~ififo_full;
      if (wen) begin
        din = in_data;
        lst = in_last;
      end
    end
  end

  // blk_cnt is a message counter here, so it only clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mode_q  <= 2'b00;
      blk_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          mode_q <= mode;
          state  <= S_MSG;
        end
      end else if (wen && in_last) begin
        state <= S_IDLE;
        done  <= 1'b1;
        if (blk_cnt != 8'hFF)
          blk_cnt <= blk_cnt + 8'd1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_keccak_msg_feeder.sv
module tb_keccak_msg_feeder;

  logic        clk, rst, start, empty_msg, in_valid, in_ready, in_last;
  logic [1:0]  mode;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        ififo_full, ififo_wen, ififo_absorb, ififo_last, busy, done;
  logic [31:0] ififo_din;
  logic [1:0]  ififo_mode;
  logic [7:0]  blk_cnt;

  keccak_msg_feeder dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .empty_msg(empty_msg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes), .ififo_full(ififo_full),
    .ififo_wen(ififo_wen), .ififo_din(ififo_din), .ififo_absorb(ififo_absorb),
    .ififo_mode(ififo_mode), .ififo_last(ififo_last), .busy(busy),
    .done(done), .blk_cnt(blk_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int tcyc = 0;
  int last_wen_cyc = -10;
  int dones = 0;
  int stall_mode = 0;
  int msg_cnt = 0;
  int exp_blk;
  logic [1:0]  cur_mode = 2'b00;
  logic [7:0]  msg_b[$];
  logic [31:0] in_words[$];
  logic [31:0] got_w[$], exp_w[$];
  logic        got_l[$], exp_l[$];

  function automatic void chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    tcyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ififo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       ififo_full = ($urandom_range(0, 2) == 0);
        2:       ififo_full = ~ififo_full;
        default: ififo_full = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("wen_while_full", (ififo_wen & ififo_full) === 1'b0);
      chk("absorb", ififo_absorb === ififo_wen);
      if (!busy) chk("idle_quiet", {in_ready, ififo_wen} === 2'b00);
      if (ififo_wen) begin
        got_w.push_back(ififo_din);
        got_l.push_back(ififo_last);
        last_wen_cyc = tcyc;
        chk("ififo_mode", ififo_mode === cur_mode);
      end
      if (done) begin
        dones++;
        chk("done_timing", tcyc === last_wen_cyc + 1);
      end
    end
  end

  function automatic int rate_words(input logic [1:0] m);
    case (m)
      2'b00:   return 42;
      2'b11:   return 18;
      default: return 34;
    endcase
  endfunction

  function automatic void build_exp(input logic [1:0] m);
`ifdef KECCAK_FEED_PAD_EN
    logic [7:0] pb[$];
    int rb;
`endif
    exp_w.delete();
    exp_l.delete();
`ifdef KECCAK_FEED_PAD_EN
    rb = 4 * rate_words(m);
    pb = msg_b;
    pb.push_back(m[1] ? 8'h06 : 8'h1F);
    while (pb.size() % rb != 0) pb.push_back(8'h00);
    pb[pb.size()-1] = pb[pb.size()-1] | 8'h80;
    for (int w = 0; w < pb.size() / 4; w++) begin
      exp_w.push_back({pb[4*w+3], pb[4*w+2], pb[4*w+1], pb[4*w]});
      exp_l.push_back(((4*w + 4) % rb) == 0);
    end
    exp_blk = pb.size() / rb;
    if (exp_blk > 255) exp_blk = 255;
`else
    for (int i = 0; i < in_words.size(); i++) begin
      exp_w.push_back(in_words[i]);
      exp_l.push_back(i == in_words.size() - 1);
    end
    exp_blk = (msg_cnt < 255) ? msg_cnt + 1 : 255;
`endif
  endfunction

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready === 1'b0);
    chk("rst_wen", ififo_wen === 1'b0);
    chk("rst_din", ififo_din === 32'h0);
    chk("rst_absorb", ififo_absorb === 1'b0);
    chk("rst_mode", ififo_mode === 2'b00);
    chk("rst_last", ififo_last === 1'b0);
    chk("rst_busy", busy === 1'b0);
    chk("rst_done", done === 1'b0);
    chk("rst_blk_cnt", blk_cnt === 8'h00);
  endtask

  task automatic run_msg(input logic [1:0] m, input int stall, input int abort_at);
    int L, n, nb_last, idx, cyc;
    logic acc, aborted;
    logic [31:0] wd;
`ifndef KECCAK_FEED_PAD_EN
    if (msg_b.size() == 0) msg_b.push_back(8'($urandom));
`endif
    L = msg_b.size();
    n = (L + 3) / 4;
    in_words.delete();
    for (int w = 0; w < n; w++) begin
      wd = $urandom;
      for (int j = 0; j < 4; j++)
        if (4*w + j < L) wd[8*j +: 8] = msg_b[4*w + j];
      in_words.push_back(wd);
    end
    nb_last = L - 4 * (n - 1);
    build_exp(m);
    stall_mode = stall;

    @(posedge clk);
    #1;
    got_w.delete();
    got_l.delete();
    dones = 0;
    cur_mode = m;
    start = 1'b1;
    mode = m;
    empty_msg = (L == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    empty_msg = 1'b0;

    idx = 0;
    cyc = 0;
    aborted = 1'b0;
    while (idx < n && cyc < 5000 && !aborted) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b0;
        #1;
        chk_reset_vals();
        chk("abort_writes", got_w.size() === abort_at);
        aborted = 1'b1;
      end else begin
        if (!in_valid) in_valid = (stall == 0) || ($urandom_range(0, 3) != 0);
        in_data  = in_words[idx];
        in_last  = (idx == n - 1);
        in_bytes = (idx == n - 1) ? 3'(nb_last) : 3'($urandom_range(0, 7));
        start     = (idx == 1);
        mode      = start ? ~m : m;
        empty_msg = start;
        @(negedge clk);
        chk("in_ready", in_ready === ~ififo_full);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
          idx++;
          in_valid = 1'b0;
        end
      end
    end
    start = 1'b0;
    mode = m;
    empty_msg = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      msg_cnt = 0;
      stall_mode = 0;
      return;
    end
    chk("words_accepted", idx === n);

    cyc = 0;
    while (dones == 0 && cyc < 600) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #2;
    chk("done_count", dones === 1);
    chk("n_writes", got_w.size() === exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      chk("word", got_w[i] === exp_w[i]);
      chk("last", got_l[i] === exp_l[i]);
    end
    chk("blk_cnt", blk_cnt === exp_blk[7:0]);
    chk("busy_after", busy === 1'b0);
    msg_cnt = exp_blk;
    stall_mode = 0;
  endtask

  task automatic fill_rand(input int nb);
    msg_b.delete();
    for (int i = 0; i < nb; i++) msg_b.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    empty_msg = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_bytes = '0;
    #3;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    msg_b.delete();
    run_msg(2'b10, 0, -1);
`ifdef KECCAK_FEED_PAD_EN
    chk("t1_size", got_w.size() === 34);
    chk("t1_w0", got_w[0] === 32'h0000_0006);
    chk("t1_w33", got_w[33] === 32'h8000_0000);
    chk("t1_blk", blk_cnt === 8'd1);
`endif

    msg_b = '{8'hEF, 8'hCD, 8'hAB};
    run_msg(2'b00, 0, -1);
`ifdef KECCAK_FEED_PAD_EN
    chk("t2_w0", got_w[0] === 32'h1FAB_CDEF);
    chk("t2_w41", got_w[41] === 32'h8000_0000);
`endif

    fill_rand(72);
    run_msg(2'b11, 0, -1);
`ifdef KECCAK_FEED_PAD_EN
    chk("t3_size", got_w.size() === 36);
    chk("t3_last17", got_l[17] === 1'b1);
    chk("t3_w18", got_w[18] === 32'h0000_0006);
    chk("t3_blk", blk_cnt === 8'd2);
`endif

    fill_rand(68);
    msg_b.push_back(8'h33);
    msg_b.push_back(8'h22);
    msg_b.push_back(8'h11);
    run_msg(2'b11, 1, -1);
`ifdef KECCAK_FEED_PAD_EN
    chk("t4_w17", got_w[17] === 32'h8611_2233);
    chk("t4_size", got_w.size() === 18);
`endif

    fill_rand(150);
    run_msg(2'b01, 2, -1);

    fill_rand(200);
    run_msg(2'b00, 0, 10);
    fill_rand(50);
    run_msg(2'b00, 0, -1);

    for (int t = 0; t < 12; t++) begin
      fill_rand($urandom_range(0, 180));
      run_msg(2'($urandom_range(0, 3)), $urandom_range(0, 2), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
